// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared segment patterns and digit-index encodings for display_mux
package display_pkg;

   typedef enum logic [1:0] {
      DIG_SEC0 = 2'd0,
      DIG_SEC1 = 2'd1,
      DIG_MIN0 = 2'd2,
      DIG_MIN1 = 2'd3
   } digit_t;

   // Active-low cathodes ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_OFF       = 4'b1111;
   localparam logic [3:0] MASK_MINUTES = 4'b1100;
   localparam logic [3:0] MASK_SECONDS = 4'b0011;

   function automatic logic [3:0] anode_for(input digit_t d);
      logic [3:0] one_hot;
      one_hot = 4'b0001 << d;
      return ~one_hot;
   endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD to active-low seven-segment decoder
module bcd_to_seg
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/display_mux.sv
// rtl/display_mux.sv - four-digit multiplexed stopwatch display with frame snapshot and adjust blink
module display_mux
   import display_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] min1,
   input  logic [3:0] min0,
   input  logic [3:0] sec1,
   input  logic [3:0] sec0,
   input  logic       adj_mode,
   input  logic       sel,
   output logic [6:0] seg,
   output logic [3:0] an
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [SW-1:0] scan_cnt;
   logic [BW-1:0] blink_cnt;
   digit_t        idx;
   logic          blink_phase;
   logic          first;
   logic [3:0]    sh_min1, sh_min0, sh_sec1, sh_sec0;
   logic [3:0]    digit_val;
   logic [3:0]    blank_mask;
   logic [6:0]    dec_seg;
   logic          scan_wrap;
   logic          frame_wrap;

   assign scan_wrap  = (scan_cnt == SCAN_LAST);
   assign frame_wrap = scan_wrap && (idx == DIG_MIN1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt <= '0;
         idx      <= DIG_SEC0;
      end else if (scan_wrap) begin
         scan_cnt <= '0;
         idx      <= digit_t'(idx + 2'd1);
      end else begin
         scan_cnt <= scan_cnt + SW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   // Shadows only change between frames so a frame never mixes old and new digits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         first   <= 1'b1;
         sh_min1 <= '0;
         sh_min0 <= '0;
         sh_sec1 <= '0;
         sh_sec0 <= '0;
      end else begin
         first <= 1'b0;
         if (first || frame_wrap) begin
            sh_min1 <= min1;
            sh_min0 <= min0;
            sh_sec1 <= sec1;
            sh_sec0 <= sec0;
         end
      end
   end

   // On the very first edge the shadows are being loaded, so show the loaded value directly
   always_comb begin
      digit_val = '0;
      case (idx)
         DIG_SEC0: digit_val = first ? sec0 : sh_sec0;
         DIG_SEC1: digit_val = first ? sec1 : sh_sec1;
         DIG_MIN0: digit_val = first ? min0 : sh_min0;
         DIG_MIN1: digit_val = first ? min1 : sh_min1;
         default:  digit_val = '0;
      endcase
   end

   always_comb begin
      blank_mask = '0;
      if (adj_mode && !blink_phase) begin
         blank_mask = sel ? MASK_SECONDS : MASK_MINUTES;
      end
   end

   bcd_to_seg u_dec (
      .bcd (digit_val),
      .seg (dec_seg)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
      end else begin
         an  <= anode_for(idx) | blank_mask;
         seg <= dec_seg;
      end
   end

endmodule
